cv_fp_cvt_fl2_f64_i32: RTL and testbench

CV_FP_CVT_FL2_F64_I32 -- requirements
Module: cv_fp_cvt_fl2_f64_i32

---
 rtl/cv_fp_pkg.sv | 25 ++
 rtl/cv_lzc32.sv | 18 +
 rtl/cv_fp_cvt_fl2_f64_i32.sv | 94 +++++++++
 tb/tb_cv_fp_cvt_fl2_f64_i32.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cv_fp_pkg.sv
// Shared IEEE-754 binary64 constants and helpers for the cv_fp converter family.
package cv_fp_pkg;

  localparam int unsigned F64_EXP_W  = 11;
  localparam int unsigned F64_FRAC_W = 52;
  localparam logic [F64_EXP_W-1:0] F64_BIAS = 11'd1023;
  localparam logic [63:0] F64_POS_ZERO = 64'h0000_0000_0000_0000;

  typedef struct packed {
    logic                  sign;
    logic [F64_EXP_W-1:0]  exp;
    logic [F64_FRAC_W-1:0] frac;
  } f64_t;

  function automatic logic [63:0] f64_pack(input logic s,
                                           input logic [F64_EXP_W-1:0] e,
                                           input logic [F64_FRAC_W-1:0] f);
    f64_t v;
    v.sign = s;
    v.exp  = e;
    v.frac = f;
    return v;
  endfunction

endpackage

// File: rtl/cv_lzc32.sv
// Combinational 32-bit leading-zero counter; zero_o flags an all-zero input (cnt_o is 0 then).
module cv_lzc32 (
  input  logic [31:0] data_i,
  output logic [4:0]  cnt_o,
  output logic        zero_o
);

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    cnt_o = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (data_i[i]) cnt_o = 5'(31 - i);
    end
  end

  assign zero_o = ~|data_i;

endmodule

// File: rtl/cv_fp_cvt_fl2_f64_i32.sv
// 32-bit integer to binary64 converter, fixed 2-cycle latency, exact (no rounding).
// Optional pipeline stall input en when CV_FP_CVT_STALL_EN is defined.
module cv_fp_cvt_fl2_f64_i32
  import cv_fp_pkg::*;
#(
  parameter int SIGNED = 1
) (
  input  logic        clk,
  input  logic        reset,
`ifdef CV_FP_CVT_STALL_EN
  input  logic        en,
`endif
  input  logic [31:0] arg,
  input  logic        arg_valid,
  output logic [63:0] result,
  output logic        result_valid
);

  // Two's-complement negate of 0x80000000 yields 0x80000000, which read unsigned is 2^31.
  function automatic logic [31:0] abs32(input logic signed [31:0] v);
    return (v < 0) ? (~$unsigned(v) + 32'd1) : $unsigned(v);
  endfunction

  logic adv;
`ifdef CV_FP_CVT_STALL_EN
  assign adv = en;
`else
  assign adv = 1'b1;
`endif

  logic signed [31:0] arg_s;
  logic               sign_d;
  logic [31:0]        mag_d;

  assign arg_s = arg;

  always_comb begin
    sign_d = 1'b0;
    mag_d  = arg;
    if (SIGNED != 0) begin
      sign_d = arg_s[31];
      mag_d  = abs32(arg_s);
    end
  end

  logic        sign_p1_q;
  logic [31:0] mag_p1_q;
  logic        vld_p1_q;

  // ---- stage 1 -> stage 2 boundary ----
  logic [4:0]            lz;
  logic                  mag_zero;
  logic [4:0]            lead_pos;
  logic [30:0]           below_lead;
  logic [F64_EXP_W-1:0]  exp_d;
  logic [F64_FRAC_W-1:0] frac_d;
  logic [63:0]           result_d;

  cv_lzc32 u_lzc (
    .data_i (mag_p1_q),
    .cnt_o  (lz),
    .zero_o (mag_zero)
  );

  assign lead_pos   = 5'd31 - lz;
  assign below_lead = 31'(mag_p1_q << lz);
  assign exp_d      = F64_BIAS + {6'd0, lead_pos};
  assign frac_d     = {below_lead, 21'd0};
  assign result_d   = mag_zero ? F64_POS_ZERO : f64_pack(sign_p1_q, exp_d, frac_d);

  logic [63:0] result_p2_q;
  logic        vld_p2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_p1_q   <= 1'b0;
      mag_p1_q    <= 32'd0;
      vld_p1_q    <= 1'b0;
      result_p2_q <= F64_POS_ZERO;
      vld_p2_q    <= 1'b0;
    end else if (adv) begin
      sign_p1_q   <= sign_d;
      mag_p1_q    <= mag_d;
      vld_p1_q    <= arg_valid;
      result_p2_q <= result_d;
      vld_p2_q    <= vld_p1_q;
    end
  end

  // ---- stage 2 output ----
  assign result       = result_p2_q;
  assign result_valid = vld_p2_q;

endmodule

// File: tb/tb_cv_fp_cvt_fl2_f64_i32.sv
// Directed and random checks for cv_fp_cvt_fl2_f64_i32, signed and unsigned instances side by side.
module tb_cv_fp_cvt_fl2_f64_i32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] arg = 32'd0;
  logic        arg_valid = 1'b0;
  logic [63:0] result_s, result_u;
  logic        result_valid_s, result_valid_u;
`ifdef CV_FP_CVT_STALL_EN
  logic        en = 1'b1;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] vin [64];
  logic [63:0] exs [64];
  logic [63:0] exu [64];
  int          nv;

  always #5 clk = ~clk;

  cv_fp_cvt_fl2_f64_i32 #(.SIGNED(1)) dut_s (
    .clk          (clk),
    .reset        (reset),
`ifdef CV_FP_CVT_STALL_EN
    .en           (en),
`endif
    .arg          (arg),
    .arg_valid    (arg_valid),
    .result       (result_s),
    .result_valid (result_valid_s)
  );

  cv_fp_cvt_fl2_f64_i32 #(.SIGNED(0)) dut_u (
    .clk          (clk),
    .reset        (reset),
`ifdef CV_FP_CVT_STALL_EN
    .en           (en),
`endif
    .arg          (arg),
    .arg_valid    (arg_valid),
    .result       (result_u),
    .result_valid (result_valid_u)
  );

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Independent reference: the simulator's own integer -> real -> bits conversion.
  function automatic logic [63:0] ref_f64(input logic [31:0] v, input bit sgn);
    real r;
    if (sgn) r = real'(int'($signed(v)));
    else     r = real'(longint'({32'd0, v}));
    return $realtobits(r);
  endfunction

  task automatic load(input int idx, input logic [31:0] a,
                      input logic [63:0] es, input logic [63:0] eu);
    vin[idx] = a;
    exs[idx] = es;
    exu[idx] = eu;
  endtask

  // Stream vin[0..nv-1] back to back; result for input i is checked after the edge i+1 later.
  task automatic run_vectors(input string tag);
    for (int i = 0; i <= nv + 1; i++) begin
      @(negedge clk);
      if (i < nv) begin
        arg = vin[i];
        arg_valid = 1'b1;
      end else begin
        arg = 32'd0;
        arg_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (i == 0) begin
        chk1({tag, "_lat_s"}, result_valid_s, 1'b0);
        chk1({tag, "_lat_u"}, result_valid_u, 1'b0);
      end else if (i - 1 < nv) begin
        chk1({tag, $sformatf("_vld_s[%0d]", i - 1)}, result_valid_s, 1'b1);
        chk64({tag, $sformatf("_res_s[%0d]", i - 1)}, result_s, exs[i - 1]);
        chk1({tag, $sformatf("_vld_u[%0d]", i - 1)}, result_valid_u, 1'b1);
        chk64({tag, $sformatf("_res_u[%0d]", i - 1)}, result_u, exu[i - 1]);
      end else begin
        chk1({tag, "_tail_vld_s"}, result_valid_s, 1'b0);
        chk1({tag, "_tail_vld_u"}, result_valid_u, 1'b0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk64("rst_res_s", result_s, 64'h0);
    chk1("rst_vld_s", result_valid_s, 1'b0);
    chk64("rst_res_u", result_u, 64'h0);
    chk1("rst_vld_u", result_valid_u, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Hand-computed directed vectors
    load(0, 32'h0000_0001, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000);
    load(1, 32'd1234567890, 64'h41D2_6580_B480_0000, 64'h41D2_6580_B480_0000);
    load(2, 32'hFFFF_FFFC, 64'hC010_0000_0000_0000, 64'h41EF_FFFF_FF80_0000);
    load(3, 32'h0000_0000, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000);
    load(4, 32'h7FFF_FFFF, 64'h41DF_FFFF_FFC0_0000, 64'h41DF_FFFF_FFC0_0000);
    load(5, 32'h8000_0000, 64'hC1E0_0000_0000_0000, 64'h41E0_0000_0000_0000);
    load(6, 32'hFFFF_FFFF, 64'hBFF0_0000_0000_0000, 64'h41EF_FFFF_FFE0_0000);
    load(7, 32'h0000_0002, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000);
    nv = 8;
    run_vectors("dir");

    // Random operands against the real-number reference
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 50; k++) begin
        logic [31:0] v;
        v = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) v = -v;
        load(k, v, ref_f64(v, 1'b1), ref_f64(v, 1'b0));
      end
      nv = 50;
      run_vectors($sformatf("rnd%0d", b));
    end

    // Reset asserted between edges with two operands in flight
    @(negedge clk);
    arg = 32'd7;
    arg_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arg = 32'hFFFF_FFF0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    arg_valid = 1'b0;
    arg = 32'd0;
    #1;
    chk64("mid_rst_res_s", result_s, 64'h0);
    chk1("mid_rst_vld_s", result_valid_s, 1'b0);
    chk64("mid_rst_res_u", result_u, 64'h0);
    chk1("mid_rst_vld_u", result_valid_u, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk1($sformatf("post_rst_vld_s[%0d]", i), result_valid_s, 1'b0);
      chk64($sformatf("post_rst_res_s[%0d]", i), result_s, 64'h0);
      chk1($sformatf("post_rst_vld_u[%0d]", i), result_valid_u, 1'b0);
    end
    load(0, 32'h0000_0003, 64'h4008_0000_0000_0000, 64'h4008_0000_0000_0000);
    load(1, 32'hFFFF_FFFE, 64'hC000_0000_0000_0000, 64'h41EF_FFFF_FFC0_0000);
    nv = 2;
    run_vectors("after_rst");

`ifdef CV_FP_CVT_STALL_EN
    // en low for three edges mid-stream: outputs frozen, nothing lost or repeated
    @(negedge clk);
    arg = 32'h0000_0001;
    arg_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arg = 32'h0000_0002;
    @(posedge clk);
    #1;
    chk64("stall_pre_res", result_s, 64'h3FF0_0000_0000_0000);
    @(negedge clk);
    en = 1'b0;
    arg = 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk1($sformatf("stall_hold_vld[%0d]", i), result_valid_s, 1'b1);
      chk64($sformatf("stall_hold_res[%0d]", i), result_s, 64'h3FF0_0000_0000_0000);
    end
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk64("stall_res1", result_s, 64'h4000_0000_0000_0000);
    @(negedge clk);
    arg = 32'h7FFF_FFFF;
    @(posedge clk);
    #1;
    chk64("stall_res2", result_s, 64'hC010_0000_0000_0000);
    @(negedge clk);
    arg_valid = 1'b0;
    arg = 32'd0;
    @(posedge clk);
    #1;
    chk1("stall_vld3", result_valid_s, 1'b1);
    chk64("stall_res3", result_s, 64'h41DF_FFFF_FFC0_0000);
    @(posedge clk);
    #1;
    chk1("stall_tail_vld", result_valid_s, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
